// File: rtl/btn_debounce_pkg.sv
// Shared types and constants for the four-channel push-button debouncer.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    RISE = 2'd1,
    HIGH = 2'd2,
    FALL = 2'd3
  } btn_state_e;

  // 10 ms at 100 MHz; benches use the short interval below
  localparam int unsigned STABLE_CYCLES_DEFAULT = 1_000_000;
  localparam int unsigned SIM_STABLE_CYCLES     = 8;

endpackage

// File: rtl/button_debouncer_if.sv
// Raw button pins in, debounced levels (and press pulses with BTN_PRESS_PULSE_EN) out.
interface button_debouncer_if;

  logic btn_up_raw;
  logic btn_down_raw;
  logic btn_left_raw;
  logic btn_right_raw;

  logic btn_up;
  logic btn_down;
  logic btn_left;
  logic btn_right;

`ifdef BTN_PRESS_PULSE_EN
  logic up_press;
  logic down_press;
  logic left_press;
  logic right_press;

  modport master (
    output btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw,
    input  btn_up, btn_down, btn_left, btn_right,
    input  up_press, down_press, left_press, right_press
  );

  modport slave (
    input  btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw,
    output btn_up, btn_down, btn_left, btn_right,
    output up_press, down_press, left_press, right_press
  );
`else
  modport master (
    output btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw,
    input  btn_up, btn_down, btn_left, btn_right
  );

  modport slave (
    input  btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw,
    output btn_up, btn_down, btn_left, btn_right
  );
`endif

endinterface

// File: rtl/debounce_channel.sv
// One button: 2-flop synchronizer, LOW/RISE/HIGH/FALL filter FSM with stability counter,
// optional rising-edge press pulse when BTN_PRESS_PULSE_EN is defined.
module debounce_channel
  import btn_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
`ifdef BTN_PRESS_PULSE_EN
  ,
  output logic press
`endif
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  btn_state_e       state_q;
  btn_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;

  // Bring the asynchronous pin into the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Counter tracks consecutive cycles at the candidate value; any disagreement restarts it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOW: begin
        cnt_d = '0;
        if (sync2_q) begin
          state_d = RISE;
          cnt_d   = CNT_W'(1);
        end
      end
      RISE: begin
        if (!sync2_q) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        cnt_d = '0;
        if (!sync2_q) begin
          state_d = FALL;
          cnt_d   = CNT_W'(1);
        end
      end
      FALL: begin
        if (sync2_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HIGH) || (state_d == FALL);
  end

  assign level = level_q;

`ifdef BTN_PRESS_PULSE_EN
  logic press_q;

  // Pulse on the same edge the level register goes 0->1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_q <= 1'b0;
    end else begin
      press_q <= level_d & ~level_q;
    end
  end

  assign press = press_q;
`endif

endmodule

// File: rtl/button_debouncer.sv
// Four independent debounce channels for up/down/left/right buttons.
// Define BTN_PRESS_PULSE_EN to add the per-channel one-cycle press outputs.
module button_debouncer
  import btn_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input logic                clk,
  input logic                reset,
  button_debouncer_if.slave  bus
);

  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_up (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn_up_raw),
    .level (bus.btn_up)
`ifdef BTN_PRESS_PULSE_EN
    ,
    .press (bus.up_press)
`endif
  );

  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_down (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn_down_raw),
    .level (bus.btn_down)
`ifdef BTN_PRESS_PULSE_EN
    ,
    .press (bus.down_press)
`endif
  );

  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_left (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn_left_raw),
    .level (bus.btn_left)
`ifdef BTN_PRESS_PULSE_EN
    ,
    .press (bus.left_press)
`endif
  );

  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_right (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn_right_raw),
    .level (bus.btn_right)
`ifdef BTN_PRESS_PULSE_EN
    ,
    .press (bus.right_press)
`endif
  );

endmodule
